ccd_pixel_capture: RTL and testbench

- Readout-side counterpart of the CCD phase generator: observes phi_p, phi_r and phi_l1 as the CCD sees them and samples the ADC output once per pixel by correlated double sampling (CDS), reset level minus signal level.
- Emits one clamped pixel word per clocked-out pixel on a valid/ready stream through a small FIFO.
- Marks the last pixel of each frame and flags overflow.
- Sits between the ADC and the frame buffer / serial uplink.

---
 rtl/ccd_pixel_capture.sv | 230 +++++++++++++++++++++++
 tb/tb_ccd_pixel_capture.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_pixel_capture.sv
// CCD readout capture: synchronises the CCD phases, takes a correlated double sample
// per pixel (reset level minus signal level) and streams clamped words through a small FIFO.
module ccd_pixel_capture #(
   parameter int ADC_W      = 12,
   parameter int NUM_PIXELS = 2048,
   parameter int SKIP       = 32,
   parameter int REF_DLY    = 4,
   parameter int SIG_DLY    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             phi_p,
   input  logic             phi_r,
   input  logic             phi_l1,
   input  logic [ADC_W-1:0] adc_data,
   output logic [ADC_W-1:0] pix_data,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic             pix_last,
   output logic             frame_active,
   output logic             overflow
);

   localparam int CW   = $clog2(SKIP + NUM_PIXELS + 1);
   localparam int DMAX = (REF_DLY > SIG_DLY) ? REF_DLY : SIG_DLY;
   localparam int DW   = $clog2(DMAX + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT_R  = 3'd1;
   localparam logic [2:0] S_DLY_REF = 3'd2;
   localparam logic [2:0] S_WAIT_L  = 3'd3;
   localparam logic [2:0] S_DLY_SIG = 3'd4;
   localparam logic [2:0] S_PUSH    = 3'd5;

   localparam logic [CW-1:0] SKIP_C   = CW'(SKIP);
   localparam logic [CW-1:0] LAST_C   = CW'(SKIP + NUM_PIXELS - 1);
   localparam logic [DW-1:0] REF_C    = DW'(REF_DLY);
   localparam logic [DW-1:0] SIG_C    = DW'(SIG_DLY);
   localparam logic [DW-1:0] DLY_ONE  = DW'(1);
   localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);

   // Reset level minus signal level, clamped at zero instead of wrapping.
   function automatic logic [ADC_W-1:0] cds_clamp(input logic [ADC_W-1:0] rst_lvl,
                                                   input logic [ADC_W-1:0] sig_lvl);
      logic [ADC_W:0] diff;
      diff = {1'b0, rst_lvl} - {1'b0, sig_lvl};
      if (diff[ADC_W]) begin
         return '0;
      end else begin
         return diff[ADC_W-1:0];
      end
   endfunction

   // Bit 0 = phi_p, bit 1 = phi_r, bit 2 = phi_l1
   logic [2:0]       r_sync1, r_sync2, r_hist;
   logic [2:0]       r_state;
   logic [DW-1:0]    r_dly;
   logic [CW-1:0]    r_cnt;
   logic             r_frame_active;
   logic             r_overflow;
   logic [ADC_W-1:0] r_ref, r_sig;
   logic [ADC_W:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr, r_rd;
   logic [AW:0]      r_count;
   logic             r_valid;

   logic             w_p_rise, w_r_fall, w_l_rise;
   logic [2:0]       w_state_nxt;
   logic [DW-1:0]    w_dly_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_fa_nxt;
   logic             w_cap_ref, w_cap_sig;
   logic             w_push, w_push_last;
   logic             w_pop, w_full, w_wr_ok;
   logic [AW:0]      w_count_nxt;

   assign w_p_rise = r_sync2[0] & ~r_hist[0];
   assign w_r_fall = ~r_sync2[1] & r_hist[1];
   assign w_l_rise = r_sync2[2] & ~r_hist[2];

   // Two-flop synchronisers plus a history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 3'b000;
         r_sync2 <= 3'b000;
         r_hist  <= 3'b000;
      end else begin
         r_sync1 <= {phi_l1, phi_r, phi_p};
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
      end
   end

   // Capture sequencer; disable beats restart, restart beats everything else
   always_comb begin
      w_state_nxt = r_state;
      w_dly_nxt   = r_dly;
      w_cnt_nxt   = r_cnt;
      w_fa_nxt    = r_frame_active;
      w_cap_ref   = 1'b0;
      w_cap_sig   = 1'b0;
      w_push      = 1'b0;
      w_push_last = 1'b0;
      if (!en) begin
         w_state_nxt = S_IDLE;
         w_fa_nxt    = 1'b0;
      end else if (w_p_rise) begin
         w_state_nxt = S_WAIT_R;
         w_cnt_nxt   = '0;
         w_fa_nxt    = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = S_IDLE;
            end
            S_WAIT_R: begin
               if (w_r_fall) begin
                  w_state_nxt = S_DLY_REF;
                  w_dly_nxt   = REF_C;
               end else begin
                  w_state_nxt = S_WAIT_R;
               end
            end
            S_DLY_REF: begin
               if (r_dly <= DLY_ONE) begin
                  w_cap_ref   = 1'b1;
                  w_state_nxt = S_WAIT_L;
               end else begin
                  w_dly_nxt = r_dly - DLY_ONE;
               end
            end
            S_WAIT_L: begin
               if (w_l_rise) begin
                  w_state_nxt = S_DLY_SIG;
                  w_dly_nxt   = SIG_C;
               end else begin
                  w_state_nxt = S_WAIT_L;
               end
            end
            S_DLY_SIG: begin
               if (r_dly <= DLY_ONE) begin
                  w_cap_sig   = 1'b1;
                  w_state_nxt = S_PUSH;
               end else begin
                  w_dly_nxt = r_dly - DLY_ONE;
               end
            end
            S_PUSH: begin
               w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
               if (r_cnt < SKIP_C) begin
                  w_state_nxt = S_WAIT_R;
               end else begin
                  w_push      = 1'b1;
                  w_push_last = (r_cnt == LAST_C);
                  if (r_cnt == LAST_C) begin
                     w_fa_nxt    = 1'b0;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_state_nxt = S_WAIT_R;
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_fa_nxt    = 1'b0;
            end
         endcase
      end
   end

   // Sequencer state and sample registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_dly          <= '0;
         r_cnt          <= '0;
         r_frame_active <= 1'b0;
         r_ref          <= '0;
         r_sig          <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_dly          <= w_dly_nxt;
         r_cnt          <= w_cnt_nxt;
         r_frame_active <= w_fa_nxt;
         r_ref          <= w_cap_ref ? adc_data : r_ref;
         r_sig          <= w_cap_sig ? adc_data : r_sig;
      end
   end

   assign w_pop       = r_valid & pix_ready;
   assign w_full      = (r_count == DEPTH_C);
   assign w_wr_ok     = w_push & (~w_full | w_pop);
   assign w_count_nxt = r_count + {{AW{1'b0}}, w_wr_ok} - {{AW{1'b0}}, w_pop};

   // Output FIFO; a push onto a full FIFO survives only if a pop frees a slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr       <= '0;
         r_rd       <= '0;
         r_count    <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_mem[r_wr] <= {w_push_last, cds_clamp(r_ref, r_sig)};
            r_wr        <= r_wr + {{(AW-1){1'b0}}, 1'b1};
         end else begin
            r_wr <= r_wr;
         end
         r_rd       <= w_pop ? r_rd + {{(AW-1){1'b0}}, 1'b1} : r_rd;
         r_count    <= w_count_nxt;
         r_valid    <= (w_count_nxt != CNT_ZERO);
         r_overflow <= r_overflow | (w_push & w_full & ~w_pop);
      end
   end

   assign pix_data     = r_mem[r_rd][ADC_W-1:0];
   assign pix_last     = r_valid & r_mem[r_rd][ADC_W];
   assign pix_valid    = r_valid;
   assign frame_active = r_frame_active;
   assign overflow     = r_overflow;

endmodule

// File: tb/tb_ccd_pixel_capture.sv
// Directed bench for ccd_pixel_capture: 4 active pixels, 1 skipped, delays of 2, FIFO depth 4.
module tb_ccd_pixel_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic        phi_p = 1'b0;
   logic        phi_r = 1'b1;
   logic        phi_l1 = 1'b0;
   logic [11:0] adc_data = 12'h000;
   logic [11:0] pix_data;
   logic        pix_valid;
   logic        pix_ready = 1'b1;
   logic        pix_last;
   logic        frame_active;
   logic        overflow;

   int          n_err = 0;
   int          n_chk = 0;
   logic [12:0] q[$];

   ccd_pixel_capture #(
      .ADC_W(12), .NUM_PIXELS(4), .SKIP(1), .REF_DLY(2), .SIG_DLY(2), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .phi_p(phi_p), .phi_r(phi_r), .phi_l1(phi_l1),
      .adc_data(adc_data), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_last(pix_last), .frame_active(frame_active), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Record every accepted word, sampled mid-cycle ahead of the popping edge
   always @(negedge clk) begin
      if (pix_valid && pix_ready) q.push_back({pix_last, pix_data});
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1, "timeout");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_word(input string tag, input int idx, input logic [11:0] d, input logic l);
      if (idx < q.size()) begin
         check_val({tag, "_data"}, {20'h0, q[idx][11:0]}, {20'h0, d});
         check_val({tag, "_last"}, {31'h0, q[idx][12]}, {31'h0, l});
      end else begin
         check_val({tag, "_missing"}, 32'h0, 32'h1);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame_start();
      phi_p = 1'b1;
      cyc(5);
      phi_p = 1'b0;
      cyc(4);
   endtask

   task automatic pixel(input logic [11:0] rv, input logic [11:0] sv);
      adc_data = rv;
      phi_r    = 1'b0;
      cyc(8);
      adc_data = sv;
      phi_l1   = 1'b1;
      cyc(8);
      phi_r    = 1'b1;
      phi_l1   = 1'b0;
      cyc(4);
   endtask

   initial begin
      cyc(3);
      check_val("rst_valid", {31'h0, pix_valid}, 32'h0);
      check_val("rst_data", {20'h0, pix_data}, 32'h0);
      check_val("rst_last", {31'h0, pix_last}, 32'h0);
      check_val("rst_fa", {31'h0, frame_active}, 32'h0);
      check_val("rst_ovf", {31'h0, overflow}, 32'h0);
      rst_n = 1'b1;
      cyc(4);

      // 1: basic frame, one skipped pixel then four 0x500 words
      q.delete();
      frame_start();
      check_val("t1_fa_start", {31'h0, frame_active}, 32'h1);
      for (int i = 0; i < 4; i++) pixel(12'h800, 12'h300);
      check_val("t1_fa_mid", {31'h0, frame_active}, 32'h1);
      pixel(12'h800, 12'h300);
      check_val("t1_fa_end", {31'h0, frame_active}, 32'h0);
      check_val("t1_count", q.size(), 32'd4);
      for (int i = 0; i < 4; i++) check_word("t1_w", i, 12'h500, i == 3);
      pixel(12'h800, 12'h300);
      check_val("t1_idle_count", q.size(), 32'd4);

      // 2: clamping and full-scale differences
      q.delete();
      frame_start();
      pixel(12'h700, 12'h100);
      pixel(12'h100, 12'h200);
      pixel(12'hFFF, 12'h000);
      pixel(12'h123, 12'h123);
      pixel(12'h001, 12'h000);
      check_val("t2_count", q.size(), 32'd4);
      check_word("t2_neg", 0, 12'h000, 1'b0);
      check_word("t2_full", 1, 12'hFFF, 1'b0);
      check_word("t2_eq", 2, 12'h000, 1'b0);
      check_word("t2_one", 3, 12'h001, 1'b1);

      // 3: backpressure, overflow on the 5th push, in-order drain
      q.delete();
      pix_ready = 1'b0;
      frame_start();
      pixel(12'h0AA, 12'h000);
      for (int i = 1; i <= 4; i++) pixel(12'(i * 16), 12'h000);
      check_val("t3_valid_hold", {31'h0, pix_valid}, 32'h1);
      check_val("t3_data_hold", {20'h0, pix_data}, 32'h010);
      check_val("t3_ovf_before", {31'h0, overflow}, 32'h0);
      frame_start();
      pixel(12'h0AA, 12'h000);
      pixel(12'h050, 12'h000);
      check_val("t3_ovf_set", {31'h0, overflow}, 32'h1);
      pixel(12'h060, 12'h000);
      pix_ready = 1'b1;
      cyc(8);
      check_val("t3_count", q.size(), 32'd4);
      for (int i = 0; i < 4; i++) check_word("t3_w", i, 12'(16 * (i + 1)), i == 3);
      check_val("t3_ovf_sticky", {31'h0, overflow}, 32'h1);
      check_val("t3_empty", {31'h0, pix_valid}, 32'h0);

      // 4: restart after two active pixels
      q.delete();
      frame_start();
      pixel(12'h0AA, 12'h000);
      pixel(12'h201, 12'h001);
      pixel(12'h302, 12'h002);
      frame_start();
      check_val("t4_fa_restart", {31'h0, frame_active}, 32'h1);
      pixel(12'h0AA, 12'h000);
      for (int i = 0; i < 4; i++) pixel(12'(12'h410 + i), 12'h010);
      check_val("t4_count", q.size(), 32'd6);
      check_word("t4_a0", 0, 12'h200, 1'b0);
      check_word("t4_a1", 1, 12'h300, 1'b0);
      for (int i = 0; i < 4; i++) check_word("t4_b", i + 2, 12'(12'h400 + i), i == 3);
      check_val("t4_fa_end", {31'h0, frame_active}, 32'h0);

      // 5: asynchronous reset in the signal-delay window
      q.delete();
      pix_ready = 1'b0;
      frame_start();
      pixel(12'h0AA, 12'h000);
      pixel(12'h0F0, 12'h000);
      adc_data = 12'h800;
      phi_r    = 1'b0;
      cyc(8);
      adc_data = 12'h100;
      phi_l1   = 1'b1;
      cyc(3);
      check_val("t5_pre_valid", {31'h0, pix_valid}, 32'h1);
      check_val("t5_pre_fa", {31'h0, frame_active}, 32'h1);
      check_val("t5_pre_ovf", {31'h0, overflow}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t5_valid", {31'h0, pix_valid}, 32'h0);
      check_val("t5_data", {20'h0, pix_data}, 32'h0);
      check_val("t5_fa", {31'h0, frame_active}, 32'h0);
      check_val("t5_ovf", {31'h0, overflow}, 32'h0);
      phi_r     = 1'b1;
      phi_l1    = 1'b0;
      pix_ready = 1'b1;
      cyc(2);
      rst_n = 1'b1;
      cyc(4);
      pixel(12'h800, 12'h100);
      check_val("t5_idle_count", q.size(), 32'd0);
      check_val("t5_idle_fa", {31'h0, frame_active}, 32'h0);

      // 6: enable dropped mid-frame, FIFO drains, no capture until re-armed
      q.delete();
      pix_ready = 1'b0;
      frame_start();
      pixel(12'h0AA, 12'h000);
      pixel(12'h111, 12'h011);
      pixel(12'h222, 12'h022);
      en = 1'b0;
      cyc(1);
      check_val("t6_fa_drop", {31'h0, frame_active}, 32'h0);
      check_val("t6_valid", {31'h0, pix_valid}, 32'h1);
      pix_ready = 1'b1;
      cyc(6);
      check_val("t6_drain", q.size(), 32'd2);
      check_word("t6_d0", 0, 12'h100, 1'b0);
      check_word("t6_d1", 1, 12'h200, 1'b0);
      pixel(12'h333, 12'h000);
      en = 1'b1;
      pixel(12'h444, 12'h000);
      check_val("t6_quiet", q.size(), 32'd2);
      frame_start();
      pixel(12'h0AA, 12'h000);
      pixel(12'h555, 12'h055);
      check_val("t6_rearm", q.size(), 32'd3);
      check_word("t6_d2", 2, 12'h500, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
